poly_voice_allocator: RTL

- Parametrised polyphonic voice allocator with per-voice linear envelope.
- Sits between the key decoder and the Synthesizer.
- Accepts note press/release events over a valid/ready handshake and assigns each note to one of VOICES voices.
- Steals the oldest voice when all voices are busy, and produces per-voice note, gate and volume outputs that the synth consumes directly.

---
 rtl/poly_voice_allocator_if.sv | 16 +
 rtl/poly_voice_allocator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_allocator_if.sv
// Note-event channel from the key decoder into the voice allocator.
// Handshake: an event transfers on a rising clk edge where ev_valid and
// ev_ready are both 1; ev_note/ev_press are meaningful only while ev_valid=1,
// the producer holds them stable until the transfer, and ev_ready never
// depends combinationally on ev_valid.
interface poly_voice_allocator_if #(
  parameter int NOTE_W = 7
);
  logic              ev_valid;
  logic              ev_ready;
  logic [NOTE_W-1:0] ev_note;
  logic              ev_press;

  modport master (output ev_valid, output ev_note, output ev_press, input ev_ready);
  modport slave  (input ev_valid, input ev_note, input ev_press, output ev_ready);
endinterface

// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: takes press/release events, scans the voices one
// per cycle to find a matching, idle or oldest voice, commits the action, and
// runs a linear attack/release envelope per voice on every tick strobe.
module poly_voice_allocator #(
  parameter int VOICES       = 8,
  parameter int NOTE_W       = 7,
  parameter int VOL_W        = 16,
  parameter int ATTACK_STEP  = 256,
  parameter int RELEASE_STEP = 64,
  parameter int AGE_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  poly_voice_allocator_if.slave         ev,
  input  logic                          tick,
  output logic [VOICES*NOTE_W-1:0]      voice_note,
  output logic [VOICES-1:0]             voice_gate,
  output logic [VOICES*VOL_W-1:0]       voice_volume,
  output logic [$clog2(VOICES+1)-1:0]   busy_count,
  output logic [1:0]                    dbg_state
);
  localparam int IDX_W = $clog2(VOICES);
  localparam int CNT_W = $clog2(VOICES+1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NOTE_W-1:0] note_q [VOICES];
  logic [NOTE_W-1:0] note_d [VOICES];
  logic [VOL_W-1:0]  vol_q  [VOICES];
  logic [VOL_W-1:0]  vol_d  [VOICES];
  logic [AGE_W-1:0]  age_q  [VOICES];
  logic [AGE_W-1:0]  age_d  [VOICES];
  logic [VOICES-1:0] gate_q, gate_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic              ev_press_q, ev_press_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic              match_found_q, match_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              idle_found_q, idle_found_d;
  logic [IDX_W-1:0]  idle_idx_q, idle_idx_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;

  logic              pick_valid;
  logic              pick_steal;
  logic [IDX_W-1:0]  pick_idx;
  logic              cur_hit;
  logic              cur_idle;

  // One envelope step, computed one bit wider and clamped so it never wraps.
  function automatic logic [VOL_W-1:0] env_step(input logic g, input logic [VOL_W-1:0] v);
    logic [VOL_W:0] s;
    if (g) begin
      s = {1'b0, v} + (VOL_W+1)'(ATTACK_STEP);
      return s[VOL_W] ? {VOL_W{1'b1}} : s[VOL_W-1:0];
    end else begin
      s = {1'b0, v} - (VOL_W+1)'(RELEASE_STEP);
      return s[VOL_W] ? '0 : s[VOL_W-1:0];
    end
  endfunction

  // Inspection of the voice currently under the scan pointer.
  always_comb begin
    cur_hit  = (note_q[scan_idx_q] == ev_note_q) &&
               (ev_press_q ? (gate_q[scan_idx_q] || (vol_q[scan_idx_q] != '0))
                           : gate_q[scan_idx_q]);
    cur_idle = !gate_q[scan_idx_q] && (vol_q[scan_idx_q] == '0);
  end

  // Choose the voice the commit acts on: match, else lowest idle, else oldest.
  always_comb begin
    pick_valid = match_found_q;
    pick_steal = 1'b0;
    pick_idx   = match_idx_q;
    if (ev_press_q && !match_found_q) begin
      pick_valid = 1'b1;
      if (idle_found_q) begin
        pick_idx = idle_idx_q;
      end else begin
        pick_idx   = old_idx_q;
        pick_steal = 1'b1;
      end
    end
  end

  // Next-state logic: envelope on tick, then FSM; the commit overrides the chosen voice.
  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    ev_note_d     = ev_note_q;
    ev_press_d    = ev_press_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    idle_found_d  = idle_found_q;
    idle_idx_d    = idle_idx_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    for (int i = 0; i < VOICES; i++) begin
      note_d[i] = note_q[i];
      age_d[i]  = age_q[i];
      vol_d[i]  = tick ? env_step(gate_q[i], vol_q[i]) : vol_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (ev.ev_valid) begin
          ev_note_d     = ev.ev_note;
          ev_press_d    = ev.ev_press;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          idle_found_d  = 1'b0;
          state_d       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!match_found_q && cur_hit) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (!idle_found_q && cur_idle) begin
          idle_found_d = 1'b1;
          idle_idx_d   = scan_idx_q;
        end
        if ((scan_idx_q == '0) || (age_q[scan_idx_q] > old_age_q)) begin
          old_idx_d = scan_idx_q;
          old_age_d = age_q[scan_idx_q];
        end
        if (scan_idx_q == IDX_W'(VOICES-1)) begin
          state_d = ST_COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        for (int i = 0; i < VOICES; i++) begin
          if (ev_press_q && (age_q[i] != {AGE_W{1'b1}})) begin
            age_d[i] = age_q[i] + 1'b1;
          end
          if (pick_valid && (IDX_W'(i) == pick_idx)) begin
            vol_d[i] = vol_q[i];
            if (ev_press_q) begin
              note_d[i] = ev_note_q;
              gate_d[i] = 1'b1;
              age_d[i]  = '0;
              if (pick_steal) begin
                vol_d[i] = '0;
              end
            end else begin
              gate_d[i] = 1'b0;
            end
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any event in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gate_q        <= '0;
      ev_note_q     <= '0;
      ev_press_q    <= 1'b0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      idle_found_q  <= 1'b0;
      idle_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        vol_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      gate_q        <= gate_d;
      ev_note_q     <= ev_note_d;
      ev_press_q    <= ev_press_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      idle_found_q  <= idle_found_d;
      idle_idx_q    <= idle_idx_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= note_d[i];
        vol_q[i]  <= vol_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  // Output packing and busy-voice count from the registered voice state.
  always_comb begin
    busy_count = '0;
    for (int i = 0; i < VOICES; i++) begin
      voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
      voice_volume[i*VOL_W +: VOL_W] = vol_q[i];
      if (gate_q[i] || (vol_q[i] != '0)) begin
        busy_count = busy_count + CNT_W'(1);
      end
    end
  end

  assign voice_gate  = gate_q;
  assign ev.ev_ready = (state_q == ST_IDLE);
  assign dbg_state   = state_q;
endmodule
